wreg_dest_tracker: RTL
======================

# wreg_dest_tracker

Parametrised successor to the write-register destination select in the multicycle MIPS datapath. It decodes the destination register (rd, rt, link register, stack pointer) from the `WriteReg` control code. It also records every issued register write in an in-order FIFO until writeback retires it, and flags read-after-write hazards on the source operands of the next instruction. It sits between the control unit and the register bank and feeds the stall logic.

## Interface
Parameters:
- `REG_W`, 5, register index width
- `DEPTH`, 4, in-flight write slots (power of two, ≥2)
- `LINK_REG`, 31, destination for code 2'b10
- `SP_REG`, 29, destination for code 2'b11

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  synchronous, active-high
- `WriteReg`  in  2  destination select code
- `imediato`  in  16  instruction immediate field; rd = `imediato[15:11]`
- `rt`  in  REG_W  rt field
- `issue_valid`  in  1  instruction issuing a register write this cycle
- `issue_ready`  out  1  tracker can accept the issue
- `retire`  in  1  oldest pending write has been committed to the register bank
- `dest_out`  out  REG_W  decoded destination (combinational)
- `head_valid`  out  1  FIFO non-empty
- `head_dest`  out  REG_W  oldest pending destination
- `rs_q`, `rt_q`  in  REG_W  source registers of the next instruction
- `hazard_rs`, `hazard_rt`  out  1  the source matches a pending destination
- `count`  out  $clog2(DEPTH)+1  pending entries
- `full`, `empty`  out  1  FIFO status
- `retire_err`  out  1  sticky: `retire` was asserted while the FIFO was empty

## Operation
- **Decode** (pure function of inputs):
  - 00 → `imediato[15:11]`
  - 01 → `rt`
  - 10 → `LINK_REG`
  - 11 → `SP_REG`
- **Push:**
  - Condition: `issue_valid && issue_ready`.
  - If `dest_out != 0`, `dest_out` is written at the tail.
  - If `dest_out == 0` ($zero), the issue is accepted but nothing is pushed.
- **`issue_ready`** = `!full || retire`. A push and a pop in the same cycle are legal when full.
- **Pop:** on `retire && !empty`, the head is removed.
- **Retire when empty:** the pop is ignored, `retire_err` is set, and it holds until `reset`.
- **Simultaneous push and pop:** `count` is unchanged and both pointers advance.
- **Pointers:** wrap modulo `DEPTH`. `count` saturates neither way, since the guards above prevent overflow and underflow.
- **Hazard:**
  - `hazard_rs` = OR over valid entries of (entry == `rs_q`), forced to 0 when `rs_q == 0`. Same rule for `hazard_rt` with `rt_q`.
  - Only registered entries count. The write being issued in the same cycle does not flag.
  - An entry popped in the current cycle still flags this cycle.
- **Reset:**
  - Pointers, `count`, `retire_err`, `head_dest` and `head_valid` go to 0.
  - `empty` goes to 1; `full` goes to 0.
  - `hazard_*` go to 0.
  - Entry contents are don't-care; valid bits are cleared.
- **Reset mid-operation:** all pending writes are discarded. A push or pop in the reset cycle is ignored.

## Timing
- `dest_out`, `issue_ready` and `hazard_*` are combinational; there is zero-cycle latency from their inputs.
- A push is visible on `count`, `head_*`, `full`/`empty` and the hazard compare at the next rising edge.
- A pop is visible at the next edge; `head_dest` then shows the next-oldest entry.
- The minimum issue-to-retire spacing is 1 cycle: push at edge N, retire sampled in the cycle after N.
- No output is registered beyond the FIFO state; `count`, `full`, `empty` and `head_*` derive from registers only.

## Structure
- Shared package `wreg_pkg`:
  - `WriteReg` encodings `WR_RD`=2'b00, `WR_RT`=2'b01, `WR_LINK`=2'b10, `WR_SP`=2'b11
  - Default `LINK_REG`/`SP_REG` constants
- Sub-module `dest_fifo`:
  - Parametrised storage, valid bits, pointers and count.
  - Exports the entry array and valid vector for the hazard compare.
- Top level holds:
  - the decode case
  - the $zero filter
  - the `retire_err` flop
  - the hazard OR-reduction

## Test plan
- **Decode and zero filter:**
  - Stimulus: `imediato`=16'h5800, `rt`=7, cycle `WriteReg` through 00..11.
  - Required: `dest_out` = 11, 7, 31, 29.
  - Then issue with `WriteReg`=00, `imediato`=0: `count` stays 0.
- **Fill to full:**
  - Stimulus: push dests 3, 4, 5, 6.
  - Required: `full`=1, `issue_ready`=0.
  - Then `issue_valid` without `retire`: `count` stays 4 and the head stays 3.
- **Full push+pop:**
  - Stimulus: when full, `issue_valid`+`retire` with dest 9.
  - Required: `count`=4, `head_dest`=4, and the FIFO later pops 4, 5, 6, 9 in order across the wrap.
- **Hazards:**
  - Stimulus: pending {8}.
  - Required:
    - `rs_q`=8 → `hazard_rs`=1.
    - `rt_q`=0 → `hazard_rt`=0.
    - Issuing dest 12 while `rs_q`=12 → 0 that cycle, 1 the next.
- **Retire on empty:**
  - Stimulus: `retire` with `count`=0.
  - Required: `retire_err`=1 next cycle and stays 1; `count` stays 0.
- **Reset mid-stream:**
  - Stimulus: 3 pending entries, assert `reset` for 1 cycle together with `issue_valid`.
  - Required: `count`=0, `empty`=1, `head_valid`=0, `retire_err`=0, and no hazards for any source.

Source files
------------

// File: rtl/wreg_pkg.sv
// Shared encodings and default constants for the write-register destination tracker.
package wreg_pkg;

  typedef enum logic [1:0] {
    WR_RD   = 2'b00,
    WR_RT   = 2'b01,
    WR_LINK = 2'b10,
    WR_SP   = 2'b11
  } wreg_sel_e;

  localparam int DEF_LINK_REG = 31;
  localparam int DEF_SP_REG   = 29;

endpackage : wreg_pkg

// File: rtl/dest_fifo.sv
// In-order FIFO of pending destination registers. It exposes the raw entry array
// and the per-slot valid bits so the parent can run the hazard compare.
module dest_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               entries [DEPTH],
  output logic [DEPTH-1:0]           valid,
  output logic [W-1:0]               head_dest,
  output logic                       head_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // NOTE: storage carries no reset; the valid bits alone decide whether a slot is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        valid[rd_ptr] <= 1'b0;
      end
      // Placed after the pop so a same-slot push+pop (full FIFO) leaves the slot valid.
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        valid[wr_ptr] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign entries    = mem;
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign head_valid = !empty;
  assign head_dest  = valid[rd_ptr] ? mem[rd_ptr] : '0;

endmodule : dest_fifo

// File: rtl/wreg_dest_tracker.sv
// Decodes the write-register destination, tracks issued writes until retirement
// and flags read-after-write hazards for the next instruction's sources.
module wreg_dest_tracker
  import wreg_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 4,
  parameter int LINK_REG = DEF_LINK_REG,
  parameter int SP_REG   = DEF_SP_REG
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             WriteReg,
  input  logic [15:0]            imediato,
  input  logic [REG_W-1:0]       rt,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   retire,
  output logic [REG_W-1:0]       dest_out,
  output logic                   head_valid,
  output logic [REG_W-1:0]       head_dest,
  input  logic [REG_W-1:0]       rs_q,
  input  logic [REG_W-1:0]       rt_q,
  output logic                   hazard_rs,
  output logic                   hazard_rt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   retire_err
);

  logic [REG_W-1:0] entries [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             push;
  logic             pop;

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    dest_out = '0;
    case (wreg_sel_e'(WriteReg))
      WR_RD:   dest_out = REG_W'(imediato[15:11]);
      WR_RT:   dest_out = rt;
      WR_LINK: dest_out = REG_W'(LINK_REG);
      WR_SP:   dest_out = REG_W'(SP_REG);
      default: dest_out = '0;
    endcase
  end

  // A retire frees a slot in the same cycle, so a full FIFO can still accept.
  assign issue_ready = !full || retire;
  // Writes to $zero are accepted but never tracked.
  assign push        = issue_valid && issue_ready && (dest_out != '0);
  assign pop         = retire && !empty;

  dest_fifo #(
    .W     (REG_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .din        (dest_out),
    .pop        (pop),
    .entries    (entries),
    .valid      (valid),
    .head_dest  (head_dest),
    .head_valid (head_valid),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_err <= 1'b0;
    end else if (retire && empty) begin
      retire_err <= 1'b1;
    end
  end

  // Only registered entries participate; the write issuing this cycle is not yet visible.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (entries[i] == rs_q)) hazard_rs = 1'b1;
      if (valid[i] && (entries[i] == rt_q)) hazard_rt = 1'b1;
    end
    if (rs_q == '0) hazard_rs = 1'b0;
    if (rt_q == '0) hazard_rt = 1'b0;
  end

endmodule : wreg_dest_tracker
